// File: rtl/mul32u_sched.sv
// Two-requester round-robin front end that time-shares one combinational 32x32
// unsigned multiplier, allowing MUL_LAT cycles for the product to settle.
module mul32u_sched #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [63:0] rsp0_res,
   output logic [63:0] rsp1_res,
   output logic        busy,
   output logic        grant_id
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [63:0] res_q, res_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic [63:0] prod_s;
   logic        win_s;
   logic        rsp_hs_s;

   Mul32U u_mul (
      .a_i (op1_q),
      .b_i (op2_q),
      .p_o (prod_s)
   );

   // Round-robin pick: on a tie the requester that did not win last time goes.
   always_comb begin
      win_s = 1'b0;
      if (req0_valid && req1_valid) begin
         win_s = ~last_q;
      end else if (req1_valid) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   assign req0_ready = (state_q == IDLE) && req0_valid && !win_s;
   assign req1_ready = (state_q == IDLE) && req1_valid &&  win_s;
   assign rsp0_valid = (state_q == RESP) && !grant_q;
   assign rsp1_valid = (state_q == RESP) &&  grant_q;
   assign rsp0_res   = res_q;
   assign rsp1_res   = res_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;
   assign rsp_hs_s   = (state_q == RESP) && (grant_q ? rsp1_ready : rsp0_ready);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      res_d   = res_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req0_ready) begin
               op1_d   = req0_op1;
               op2_d   = req0_op2;
               grant_d = 1'b0;
               last_d  = 1'b0;
               cnt_d   = CNT_INIT;
               state_d = CALC;
            end else if (req1_ready) begin
               op1_d   = req1_op1;
               op2_d   = req1_op2;
               grant_d = 1'b1;
               last_d  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            // Product is only trusted once the settle budget has run out.
            if (cnt_q == 4'd0) begin
               res_d   = prod_s;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_hs_s) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; last_q resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op1_q   <= 32'd0;
         op2_q   <= 32'd0;
         res_q   <= 64'd0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end
endmodule

// Full-width combinational unsigned multiplier.
module Mul32U (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] p_o
);
   assign p_o = 64'(a_i) * 64'(b_i);
endmodule

// File: tb/tb_mul32u_sched.sv
// Bench for mul32u_sched: main instance at MUL_LAT=2 plus MUL_LAT=1 and 15
// instances sharing the same stimulus, checked against a transaction-level model.
module tb_mul32u_sched;
   localparam int LA = 2;
   localparam int LB = 1;
   localparam int LC = 15;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic        rsp0_ready, rsp1_ready;

   logic [2:0]  req0_ready_w, req1_ready_w, rsp0_valid_w, rsp1_valid_w, busy_w, grant_id_w;
   logic [63:0] rsp0_res_w [3];
   logic [63:0] rsp1_res_w [3];

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   logic m_last;

   mul32u_sched #(.MUL_LAT(LA)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready_w[0]), .req1_ready(req1_ready_w[0]),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .rsp0_valid(rsp0_valid_w[0]), .rsp1_valid(rsp1_valid_w[0]),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp0_res(rsp0_res_w[0]), .rsp1_res(rsp1_res_w[0]),
      .busy(busy_w[0]), .grant_id(grant_id_w[0])
   );

   mul32u_sched #(.MUL_LAT(LB)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready_w[1]), .req1_ready(req1_ready_w[1]),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .rsp0_valid(rsp0_valid_w[1]), .rsp1_valid(rsp1_valid_w[1]),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp0_res(rsp0_res_w[1]), .rsp1_res(rsp1_res_w[1]),
      .busy(busy_w[1]), .grant_id(grant_id_w[1])
   );

   mul32u_sched #(.MUL_LAT(LC)) dut15 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready_w[2]), .req1_ready(req1_ready_w[2]),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .rsp0_valid(rsp0_valid_w[2]), .rsp1_valid(rsp1_valid_w[2]),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp0_res(rsp0_res_w[2]), .rsp1_res(rsp1_res_w[2]),
      .busy(busy_w[2]), .grant_id(grant_id_w[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      case (i)
         0:       return LA;
         1:       return LB;
         default: return LC;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_op1 = 32'd0; req0_op2 = 32'd0; req1_op1 = 32'd0; req1_op2 = 32'd0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if ({busy_w[i], rsp1_valid_w[i], rsp0_valid_w[i], req1_ready_w[i], req0_ready_w[i], grant_id_w[i]} !== 6'b0
             || rsp0_res_w[i] !== 64'd0 || rsp1_res_w[i] !== 64'd0) begin
            err_cnt++;
            $display("FAIL reset[%0d]: busy=%b rsp_v=%b%b rdy=%b%b gid=%b res=%h required all zero",
                     i, busy_w[i], rsp1_valid_w[i], rsp0_valid_w[i], req1_ready_w[i], req0_ready_w[i],
                     grant_id_w[i], rsp0_res_w[i]);
         end
      end
      rst = 1'b0;
      m_last = 1'b1;
   endtask

   // One complete transaction on the main instance; caller must leave it in IDLE.
   task automatic one_txn(input logic u0, input logic u1, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1, input int hold, input string tag);
      logic        w;
      logic [63:0] p;
      int          n;
      w = (u0 && u1) ? ~m_last : u1;
      p = w ? (64'(a1) * 64'(b1)) : (64'(a0) * 64'(b0));
      req0_valid = u0; req1_valid = u1;
      req0_op1 = a0; req0_op2 = b0; req1_op1 = a1; req1_op2 = b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      vec_cnt++;
      if ({req1_ready_w[0], req0_ready_w[0]} !== {w, ~w}) begin
         err_cnt++;
         $display("FAIL %s grant: ready=%b%b required %b%b", tag, req1_ready_w[0], req0_ready_w[0], w, ~w);
      end
      tick();
      // Buses change while busy; the captured operands must not.
      req0_valid = 1'($urandom_range(1, 0)); req1_valid = 1'($urandom_range(1, 0));
      req0_op1 = $urandom(); req0_op2 = $urandom(); req1_op1 = $urandom(); req1_op2 = $urandom();
      #1;
      n = 0;
      while (n < 40 && rsp0_valid_w[0] === 1'b0 && rsp1_valid_w[0] === 1'b0) begin
         vec_cnt++;
         if (busy_w[0] !== 1'b1 || req0_ready_w[0] !== 1'b0 || req1_ready_w[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s calc: busy=%b ready=%b%b required busy=1 ready=00", tag, busy_w[0],
                     req1_ready_w[0], req0_ready_w[0]);
         end
         n++;
         tick();
      end
      vec_cnt++;
      if (n !== LA) begin
         err_cnt++;
         $display("FAIL %s latency: %0d calc cycles, required %0d", tag, n, LA);
      end
      for (int h = 0; h <= hold; h++) begin
         vec_cnt++;
         if ({rsp1_valid_w[0], rsp0_valid_w[0]} !== {w, ~w} || rsp0_res_w[0] !== p || rsp1_res_w[0] !== p
             || grant_id_w[0] !== w || busy_w[0] !== 1'b1 || req0_ready_w[0] !== 1'b0 || req1_ready_w[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s resp[%0d]: rsp_v=%b%b res=%h/%h gid=%b busy=%b rdy=%b%b required rsp_v=%b%b res=%h gid=%b",
                     tag, h, rsp1_valid_w[0], rsp0_valid_w[0], rsp0_res_w[0], rsp1_res_w[0], grant_id_w[0],
                     busy_w[0], req1_ready_w[0], req0_ready_w[0], w, ~w, p, w);
         end
         if (h < hold) begin
            rsp0_ready = w ? 1'($urandom_range(1, 0)) : 1'b0;
            rsp1_ready = w ? 1'b0 : 1'($urandom_range(1, 0));
            tick();
         end
      end
      rsp0_ready = ~w; rsp1_ready = w;
      tick();
      vec_cnt++;
      if (busy_w[0] !== 1'b0 || rsp0_valid_w[0] !== 1'b0 || rsp1_valid_w[0] !== 1'b0) begin
         err_cnt++;
         $display("FAIL %s release: busy=%b rsp_v=%b%b required idle", tag, busy_w[0], rsp1_valid_w[0], rsp0_valid_w[0]);
      end
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      m_last = w;
   endtask

   task automatic test_products();
      one_txn(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, "max_sq");
      one_txn(1'b1, 1'b0, 32'd0, 32'h1234_5678, 32'd5, 32'd7, 0, "zero");
      one_txn(1'b0, 1'b1, 32'd3, 32'd3, 32'h0000_0001, 32'hFFFF_FFFF, 1, "one_x_max");
   endtask

   task automatic test_rsp_stall();
      one_txn(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, 32'd0, 5, "stall5");
   endtask

   task automatic test_back_to_back();
      int   hs_cyc[$];
      logic hs_id[$];
      test_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op1 = 32'h0001_0000; req0_op2 = 32'h0001_0000;
      req1_op1 = 32'h0001_0000; req1_op2 = 32'h0001_0000;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 4 * (LA + 2); i++) begin
         #1;
         if (req0_ready_w[0] === 1'b1) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b0); end
         if (req1_ready_w[0] === 1'b1) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b1); end
         if (rsp0_valid_w[0] === 1'b1 || rsp1_valid_w[0] === 1'b1) begin
            vec_cnt++;
            if (rsp0_res_w[0] !== 64'h0000_0001_0000_0000) begin
               err_cnt++;
               $display("FAIL b2b res: %h required 0000000100000000", rsp0_res_w[0]);
            end
         end
         tick();
      end
      vec_cnt++;
      if (hs_cyc.size() < 4) begin
         err_cnt++;
         $display("FAIL b2b count: %0d handshakes, required at least 4", hs_cyc.size());
      end
      for (int k = 0; k < hs_cyc.size(); k++) begin
         vec_cnt++;
         if (hs_id[k] !== 1'(k % 2)) begin
            err_cnt++;
            $display("FAIL b2b order[%0d]: grant %b required %b", k, hs_id[k], 1'(k % 2));
         end
         if (k > 0) begin
            vec_cnt++;
            if (hs_cyc[k] - hs_cyc[k-1] !== LA + 2) begin
               err_cnt++;
               $display("FAIL b2b period[%0d]: %0d cycles required %0d", k, hs_cyc[k] - hs_cyc[k-1], LA + 2);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      test_reset();
      req0_valid = 1'b1; req0_op1 = 32'd1000; req0_op2 = 32'd2000;
      tick();
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      vec_cnt++;
      if ({busy_w[0], rsp1_valid_w[0], rsp0_valid_w[0], req1_ready_w[0], req0_ready_w[0], grant_id_w[0]} !== 6'b0
          || rsp0_res_w[0] !== 64'd0) begin
         err_cnt++;
         $display("FAIL rst_mid: busy=%b rsp_v=%b%b rdy=%b%b gid=%b res=%h required all zero", busy_w[0],
                  rsp1_valid_w[0], rsp0_valid_w[0], req1_ready_w[0], req0_ready_w[0], grant_id_w[0], rsp0_res_w[0]);
      end
      tick();
      rst = 1'b0;
      m_last = 1'b1;
      one_txn(1'b0, 1'b1, 32'd0, 32'd0, 32'h8000_0000, 32'd4, 0, "post_rst");
   endtask

   task automatic test_latency(input logic [31:0] a, input logic [31:0] b);
      int          first [3];
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b;
      #1;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (req0_ready_w[i] !== 1'b1) begin
            err_cnt++;
            $display("FAIL lat[%0d] accept: ready0=%b required 1", lat_of(i), req0_ready_w[i]);
         end
         first[i] = -1;
      end
      tick();
      req0_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (first[i] < 0 && rsp0_valid_w[i] === 1'b1) begin
               first[i] = c;
               vec_cnt++;
               if (rsp0_res_w[i] !== p || rsp1_valid_w[i] !== 1'b0) begin
                  err_cnt++;
                  $display("FAIL lat[%0d] res: %h rsp1_v=%b required %h rsp1_v=0", lat_of(i), rsp0_res_w[i],
                           rsp1_valid_w[i], p);
               end
            end
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (first[i] !== lat_of(i) + 1) begin
            err_cnt++;
            $display("FAIL lat[%0d] cycles: rsp after %0d required %0d", lat_of(i), first[i], lat_of(i) + 1);
         end
      end
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (busy_w[i] !== 1'b0) begin
            err_cnt++;
            $display("FAIL lat[%0d] release: busy=%b required 0", lat_of(i), busy_w[i]);
         end
      end
      m_last = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0] u;
      for (int t = 0; t < 40; t++) begin
         u = 2'($urandom_range(3, 1));
         one_txn(u[0], u[1], $urandom(), $urandom(), $urandom(), $urandom(),
                 int'($urandom_range(3, 0)), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_rsp_stall();
      test_back_to_back();
      test_reset_mid();
      test_latency(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_latency(32'd0, 32'h1234_5678);
      test_latency(32'h0000_0001, 32'hFFFF_FFFF);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/mul32u_sched.md
MUL32U_SCHED -- requirements
Module: mul32u_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, giving the number of CALC cycles allowed for the combinational Mul32U product to settle; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  scheduler accepts requester 0/1 this cycle.
REQ-006 SHALL have ports req0_op1, req0_op2, req1_op1, req1_op2  input  32  unsigned operands.
REQ-007 SHALL have ports rsp0_valid / rsp1_valid  output  1  result available for requester 0/1.
REQ-008 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester 0/1 takes the result.
REQ-009 SHALL have ports rsp0_res / rsp1_res  output  64  unsigned product; both driven from one result register.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port grant_id  output  1  owner of the current or most recent transaction.

Function
REQ-012 SHALL instantiate exactly one Mul32U, fed from internal operand registers op1_q and op2_q.
REQ-013 SHALL implement an FSM with states IDLE, CALC and RESP.
REQ-014 SHALL, in IDLE only, assert reqN_ready for the arbitration winner and hold the other ready low; both readys SHALL be low in CALC and RESP.
REQ-015 SHALL arbitrate combinationally: a single valid requester wins; when both are valid, the requester not equal to last_grant wins (round-robin).
REQ-016 SHALL, on reqN_valid && reqN_ready, capture opN_op1/op2 into op1_q/op2_q, set grant_id = N and last_grant = N, load the counter with MUL_LAT-1, and enter CALC.
REQ-017 SHALL, in CALC, decrement the counter each cycle while holding op1_q and op2_q stable.
REQ-018 SHALL, in the CALC cycle where the counter equals 0, register the Mul32U product into res_q and enter RESP.
REQ-019 SHALL give a latency where a handshake in cycle k yields rspN_valid high from cycle k+MUL_LAT+1.
REQ-020 SHALL, in RESP, assert only rsp[grant_id]_valid and hold res_q constant until rsp[grant_id]_ready is high.
REQ-021 SHALL, when rsp_valid && rsp_ready are both high, return to IDLE on the next edge; there SHALL be no new accept in that same cycle, giving a back-to-back period of MUL_LAT+2 cycles.
REQ-022 SHALL ignore rsp_ready from the non-owner and ignore any reqN_valid changes outside IDLE.
REQ-023 SHALL produce the full 64-bit product (op1 × op2 < 2^64); no truncation, no overflow flag.
REQ-024 SHALL place a requirement on requesters: a requester SHALL hold op1/op2 stable while valid && !ready; the scheduler never drops a valid request, which waits until granted.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, counter=0, op1_q=op2_q=0, res_q=0, grant_id=0, last_grant=1 (requester 0 wins the first tie), rsp0_valid=rsp1_valid=0, and busy=0.
REQ-026 SHALL, when rst is asserted mid-transaction (CALC or RESP), discard the transaction with no response ever issued for it, and accept requests again in the first cycle after rst deasserts.
REQ-027 SHALL drive req0_ready and req1_ready during reset from combinational arbitration gated by IDLE, so no handshake is registered while rst=1.

Verification
REQ-028 SHALL cover: MUL_LAT=2, req0 0xFFFFFFFF × 0xFFFFFFFF accepted in cycle k -> rsp0_valid in k+3, rsp0_res=0xFFFFFFFE00000001, rsp1_valid=0.
REQ-029 SHALL cover: both requesters valid continuously from reset with rsp_ready=1 -> grants alternate 0,1,0,1 with each period MUL_LAT+2, and 0x10000 × 0x10000 -> 0x0000000100000000.
REQ-030 SHALL cover: rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp0_res stable, both readys 0 and busy=1 throughout; release -> IDLE next cycle.
REQ-031 SHALL cover: rst pulsed during CALC -> all outputs 0 in the reset cycle, no rsp_valid for that transaction, and a fresh req1 accepted in the first post-reset cycle.
REQ-032 SHALL cover: operand 0 × 0x12345678 -> 0, and 0x00000001 × 0xFFFFFFFF -> 0x00000000FFFFFFFF.
REQ-033 SHALL cover: MUL_LAT=1 and MUL_LAT=15 builds -> latency exactly MUL_LAT+1 and correct products for the cases above.
